coarse_cfo_mul_sched: RTL
=========================

Name: coarse_cfo_mul_sched

Overview:
Time-shares one 32-bit signed × 28-bit unsigned multiplier (48-bit truncated result) between NUM_REQ requesters inside the coarse CFO path. Requesters include autocorrelation normalisation, angle scaling and phase-increment generation. Arbitration is round-robin, with a valid/ready request handshake per requester and one tagged response stream that supports backpressure. The block sits between the CFO estimator sub-blocks and the shared multiplier datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
A_W, 32, signed operand width
B_W, 28, unsigned operand width
P_W, 48, result width (low bits of the full product)
MUL_STAGES, 1, register stages inside the multiply path (1..3)
ID_W, 2, response tag width, equal to clog2(NUM_REQ)

Ports:
ap_clk  in  1  clock; all logic on the rising edge
ap_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept
req_a  in  NUM_REQ*A_W  packed signed operands; requester i at [i*A_W +: A_W]
req_b  in  NUM_REQ*B_W  packed unsigned operands
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_data  out  P_W  product, low P_W bits
rsp_id  out  ID_W  index of the requester that issued the operation
rsp_ovf  out  1  full product not representable in P_W signed bits
ovf_cnt  out  16  saturating count of overflowed results delivered

Behaviour:
- Reset (asynchronous, ap_rst_n=0):
  - all pipeline valid bits cleared; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_ovf=0; ovf_cnt=0; req_ready=0.
  - round-robin pointer (last granted index) set to NUM_REQ-1, so requester 0 wins first.
  - reset mid-operation discards in-flight operations; no response is ever produced for them.
- Advance rule:
  - adv = !rsp_valid || rsp_ready.
  - the whole pipeline (input register, MUL_STAGES stages, output register) shifts only when adv=1, otherwise it holds.
- Arbitration (combinational):
  - grant = first i with req_valid[i]=1, scanning cyclically from pointer+1.
  - req_ready[i] = adv && grant_valid && (grant==i); at most one bit set.
  - req_ready must not depend on the value of req_a/req_b.
- Accept:
  - on an edge with req_valid[i]&&req_ready[i], capture req_a[i], req_b[i] and id=i into the input register, and set pointer=i.
  - with no accept and adv=1, insert a bubble (valid=0).
- Arithmetic:
  - full = signed(a) × signed({1'b0,b}) as a 60-bit signed value.
  - rsp_data = full[P_W-1:0] (wraps).
  - rsp_ovf = 1 iff full[59:P_W-1] is not all-equal.
- Latency: the result appears on rsp_valid exactly MUL_STAGES+1 rising edges after the accepting edge, provided adv stays 1.
- Throughput: one operation per cycle with rsp_ready held at 1.
- Output stability: while rsp_valid=1 && rsp_ready=0, rsp_data, rsp_id and rsp_ovf are held stable.
- ovf_cnt: increments on a response handshake with rsp_ovf=1; saturates at 0xFFFF.
- Simultaneous output handshake and new accept: both occur in the same cycle with no bubble.
- Requester drops req_valid before grant: permitted, nothing is issued.
- Ordering: responses leave in accept order.
- Fairness: a continuously requesting requester is granted within NUM_REQ accepts.

Decomposition:
- Shared package coarse_cfo_pkg holds:
  - constants A_W, B_W, P_W and FULL_W=A_W+B_W;
  - a request struct {a, b, id};
  - a response struct {data, id, ovf}.
- One sub-module: coarse_cfo_rr_arb. It is a parameterised NUM_REQ round-robin arbiter taking req, pointer and enable, and producing grant_onehot, grant_idx and grant_valid.
- The multiply pipeline stays inline.

Test Plan:
- Single op: requester 0 sends a=-3, b=5 with rsp_ready=1 → exactly 2 edges later rsp_valid=1, rsp_data=48'hFFFF_FFFF_FFF1, rsp_id=0, rsp_ovf=0.
- Fairness: all four req_valid held high for 8 accepts with rsp_ready=1 → grant order 0,1,2,3,0,1,2,3; rsp_id follows the same order back-to-back with no bubbles.
- Backpressure: stream operands a=1..6, b=1; hold rsp_ready=0 for 5 cycles after the first rsp_valid → req_ready=0 once the pipeline is full, rsp_data=1 held stable; release → results 1..6 in order, none lost or duplicated.
- Overflow: a=32'h7FFF_FFFF, b=28'hFFF_FFFF → rsp_data=48'hFFFF_7000_0001, rsp_ovf=1, ovf_cnt 0→1. Edge case a=32'h8000_0000, b=0 → rsp_data=0, rsp_ovf=0.
- Reset mid-operation: assert ap_rst_n=0 asynchronously with 2 operations in flight → rsp_valid drops immediately. After release, no stale responses; first grant goes to requester 0 even if requester 2 is also valid.
- Sparse requests: only requester 3 valid, then only requester 1 → each is granted on its first valid cycle (no idle wait); pointer updates to 3, then 1.

Source files
------------

// File: rtl/coarse_cfo_pkg.sv
// rtl/coarse_cfo_pkg.sv - shared widths, request/response structs and product helper
package coarse_cfo_pkg;

  localparam int A_W    = 32;
  localparam int B_W    = 28;
  localparam int P_W    = 48;
  localparam int FULL_W = A_W + B_W;
  localparam int TAG_W  = 3;

  typedef struct packed {
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic [TAG_W-1:0] id;
  } mul_req_t;

  typedef struct packed {
    logic [P_W-1:0]   data;
    logic [TAG_W-1:0] id;
    logic             ovf;
  } mul_rsp_t;

  // The true product always fits in FULL_W signed bits, so a modular multiply is exact.
  function automatic mul_rsp_t mul_eval(input mul_req_t r);
    logic [FULL_W-1:0] full;
    mul_rsp_t          o;
    full   = {{B_W{r.a[A_W-1]}}, r.a} * {{A_W{1'b0}}, r.b};
    o.data = full[P_W-1:0];
    o.id   = r.id;
    o.ovf  = !((&full[FULL_W-1:P_W-1]) || !(|full[FULL_W-1:P_W-1]));
    return o;
  endfunction

endpackage

// File: rtl/coarse_cfo_rr_arb.sv
// rtl/coarse_cfo_rr_arb.sv - round-robin arbiter scanning from the slot after ptr
module coarse_cfo_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int idx;
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    idx          = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (en && !grant_valid && req[idx]) begin
        grant_valid       = 1'b1;
        grant_idx         = IDX_W'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coarse_cfo_mul_sched.sv
// rtl/coarse_cfo_mul_sched.sv - round-robin shared signed x unsigned multiplier with tagged responses
module coarse_cfo_mul_sched
  import coarse_cfo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MUL_STAGES = 1,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [P_W-1:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_ovf,
  output logic [15:0]            ovf_cnt
);

  logic                  adv;
  logic                  grant_valid;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       ptr;
  logic [NUM_REQ-1:0]    grant_onehot;
  logic                  in_vld;
  mul_req_t              in_req;
  logic [MUL_STAGES-1:0] stg_vld;
  mul_rsp_t              stg [MUL_STAGES];
  logic                  out_vld;
  mul_rsp_t              out_rsp;
  logic                  unused_id;

  // The whole pipeline moves as one unit, so a stalled output freezes every stage.
  assign adv = !out_vld || rsp_ready;

  coarse_cfo_rr_arb #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (ID_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (ptr),
    .en          (adv && ap_rst_n),
    .grant_onehot(grant_onehot),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant_onehot;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr <= ID_W'(NUM_REQ - 1);
    end else if (grant_valid) begin
      ptr <= grant_idx;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      in_vld  <= 1'b0;
      in_req  <= '0;
      stg_vld <= '0;
      for (int k = 0; k < MUL_STAGES; k++) stg[k] <= '0;
      out_vld <= 1'b0;
      out_rsp <= '0;
    end else if (adv) begin
      in_vld <= grant_valid;
      if (grant_valid) begin
        in_req.a  <= req_a[grant_idx*A_W +: A_W];
        in_req.b  <= req_b[grant_idx*B_W +: B_W];
        in_req.id <= TAG_W'(grant_idx);
      end
      stg_vld[0] <= in_vld;
      stg[0]     <= mul_eval(in_req);
      for (int k = 1; k < MUL_STAGES; k++) begin
        stg_vld[k] <= stg_vld[k-1];
        stg[k]     <= stg[k-1];
      end
      out_vld <= stg_vld[MUL_STAGES-1];
      out_rsp <= stg[MUL_STAGES-1];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ovf_cnt <= '0;
    end else if (out_vld && rsp_ready && out_rsp.ovf && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  assign rsp_valid = out_vld;
  assign rsp_data  = out_rsp.data;
  assign rsp_id    = out_rsp.id[ID_W-1:0];
  assign rsp_ovf   = out_rsp.ovf;
  assign unused_id = ^out_rsp.id;

endmodule
